// File: rtl/mm_accel_ctrl_tiled.sv
`timescale 1ns/1ps
// Control FSM for the row-oriented matrix-multiply accelerator: A-row load, K-tile MAC, C-row store.
// Optional per-phase watchdog is built when MM_CTRL_TIMEOUT_EN is defined.
module mm_accel_ctrl_tiled #(
  parameter  int unsigned MAX_ROWS       = 16,
  parameter  int unsigned MAX_KTILES     = 8,
  parameter  int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned ROW_W          = $clog2(MAX_ROWS + 1),
  localparam int unsigned KT_W           = $clog2(MAX_KTILES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ROW_W-1:0] cfg_rows,
  input  logic [KT_W-1:0]  cfg_ktiles,
  input  logic             abort,
  input  logic             a_done,
  input  logic             mac_done,
  input  logic             c_done,
  output logic             load_a_en,
  output logic             mac_en,
  output logic             mac_clear,
  output logic             store_c_en,
  output logic [ROW_W-1:0] row_idx,
  output logic [KT_W-1:0]  ktile_idx,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code
);

  // Phase states use their watchdog error code as their low two bits.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_MAC     = 3'd2,
    S_STORE_C = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] rows_q, rows_d, row_q, row_d;
  logic [KT_W-1:0]  ktiles_q, ktiles_d, kt_q, kt_d;
  logic             load_a_en_q, load_a_en_d;
  logic             mac_en_q, mac_en_d;
  logic             mac_clear_q, mac_clear_d;
  logic             store_c_en_q, store_c_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

`ifdef MM_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             in_phase_c;
`endif

  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    ktiles_d = ktiles_q;
    row_d    = row_q;
    kt_d     = kt_q;
`ifdef MM_CTRL_TIMEOUT_EN
    err_d      = err_q;
    err_code_d = err_code_q;
    in_phase_c = (state_q == S_LOAD_A) || (state_q == S_MAC) || (state_q == S_STORE_C);
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_d   = cfg_rows;
          ktiles_d = (cfg_ktiles == '0) ? KT_W'(1) : cfg_ktiles;
          row_d    = '0;
          kt_d     = '0;
          state_d  = (cfg_rows == '0) ? S_DONE : S_LOAD_A;
`ifdef MM_CTRL_TIMEOUT_EN
          err_d      = 1'b0;
          err_code_d = 2'b00;
`endif
        end
      end
      S_LOAD_A: begin
        if (a_done) state_d = S_MAC;
      end
      S_MAC: begin
        if (mac_done) begin
          if (kt_q == ktiles_q - KT_W'(1)) begin
            state_d = S_STORE_C;
          end else begin
            kt_d    = kt_q + KT_W'(1);
            state_d = S_LOAD_A;
          end
        end
      end
      S_STORE_C: begin
        if (c_done) begin
          if (row_q == rows_q - ROW_W'(1)) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + ROW_W'(1);
            kt_d    = '0;
            state_d = S_LOAD_A;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef MM_CTRL_TIMEOUT_EN
    // Watchdog fires only when the phase is still waiting on its own done.
    if (in_phase_c && !abort && (state_d == state_q) &&
        (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
      state_d    = S_IDLE;
      err_d      = 1'b1;
      err_code_d = 2'(state_q);
    end
`endif

    // Abort overrides any completion in the same cycle and leaves indices untouched.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      row_d   = row_q;
      kt_d    = kt_q;
    end

`ifdef MM_CTRL_TIMEOUT_EN
    if (state_d != state_q) cnt_d = '0;
    else if (in_phase_c)    cnt_d = cnt_q + CNT_W'(1);
    else                    cnt_d = cnt_q;
`endif

    load_a_en_d  = (state_d == S_LOAD_A);
    mac_en_d     = (state_d == S_MAC);
    mac_clear_d  = (state_d == S_MAC) && (state_q != S_MAC) && (kt_d == '0);
    store_c_en_d = (state_d == S_STORE_C);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rows_q       <= '0;
      ktiles_q     <= '0;
      row_q        <= '0;
      kt_q         <= '0;
      load_a_en_q  <= 1'b0;
      mac_en_q     <= 1'b0;
      mac_clear_q  <= 1'b0;
      store_c_en_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef MM_CTRL_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
      err_code_q   <= 2'b00;
`endif
    end else begin
      state_q      <= state_d;
      rows_q       <= rows_d;
      ktiles_q     <= ktiles_d;
      row_q        <= row_d;
      kt_q         <= kt_d;
      load_a_en_q  <= load_a_en_d;
      mac_en_q     <= mac_en_d;
      mac_clear_q  <= mac_clear_d;
      store_c_en_q <= store_c_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef MM_CTRL_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
`endif
    end
  end

  assign load_a_en  = load_a_en_q;
  assign mac_en     = mac_en_q;
  assign mac_clear  = mac_clear_q;
  assign store_c_en = store_c_en_q;
  assign row_idx    = row_q;
  assign ktile_idx  = kt_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef MM_CTRL_TIMEOUT_EN
  assign err      = err_q;
  assign err_code = err_code_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign err      = 1'b0;
  assign err_code = 2'b00;
`endif

endmodule

// File: tb/tb_mm_accel_ctrl_tiled.sv
`timescale 1ns/1ps
// Randomised bench for mm_accel_ctrl_tiled: each job is expanded into its expected phase plan
// (rows x ktiles LOAD_A/MAC pairs plus one STORE_C per row) and the outputs are checked every cycle.
module tb_mm_accel_ctrl_tiled;

  localparam int unsigned TO = 16;
  localparam logic [1:0] P_IDLE = 2'd0, P_LOAD = 2'd1, P_MAC = 2'd2, P_STORE = 2'd3;

  typedef struct packed {
    logic [1:0] ph;
    logic [4:0] row;
    logic [3:0] kt;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, a_done, mac_done, c_done;
  logic [4:0] cfg_rows;
  logic [3:0] cfg_ktiles;
  logic       load_a_en, mac_en, mac_clear, store_c_en, busy, done, err;
  logic [1:0] err_code;
  logic [4:0] row_idx;
  logic [3:0] ktile_idx;

  int         n_chk = 0;
  int         n_fail = 0;
  int         job_no = 0;
  logic       exp_err;
  logic [1:0] exp_code;
  item_t      plan[$];

  always #5 clk = ~clk;

  mm_accel_ctrl_tiled #(.MAX_ROWS(16), .MAX_KTILES(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows), .cfg_ktiles(cfg_ktiles),
    .abort(abort), .a_done(a_done), .mac_done(mac_done), .c_done(c_done),
    .load_a_en(load_a_en), .mac_en(mac_en), .mac_clear(mac_clear), .store_c_en(store_c_en),
    .row_idx(row_idx), .ktile_idx(ktile_idx), .busy(busy), .done(done),
    .err(err), .err_code(err_code)
  );

  function automatic logic [17:0] obs_vec();
    return {load_a_en, mac_en, mac_clear, store_c_en, busy, done, err, err_code, row_idx, ktile_idx};
  endfunction

  function automatic logic [17:0] exp_vec(input logic [1:0] ph, input logic clr, input logic bz,
                                          input logic dn, input logic [4:0] r, input logic [3:0] k);
    return {ph == P_LOAD, ph == P_MAC, clr, ph == P_STORE, bz, dn, exp_err, exp_code, r, k};
  endfunction

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %05h expected %05h", tag, got, want);
    end
  endtask

  // Own-phase done only when requested; other done inputs and start are random noise.
  task automatic drive(input logic [1:0] ph, input bit own);
    a_done   = (ph == P_LOAD)  ? own : 1'($urandom_range(1, 0));
    mac_done = (ph == P_MAC)   ? own : 1'($urandom_range(1, 0));
    c_done   = (ph == P_STORE) ? own : 1'($urandom_range(1, 0));
    start    = ($urandom_range(3, 0) == 0);
  endtask

  task automatic quiet();
    a_done = 1'b0; mac_done = 1'b0; c_done = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  task automatic run_job(input int rows, input int kts, input int dmin, input int dmax,
                         input int abort_at, input int stall_at, input bit abort_with_start);
    int keff, ncyc;
    item_t it;
    logic [4:0] fr;
    logic [3:0] fk;
    job_no++;
    keff = (kts == 0) ? 1 : kts;
    plan.delete();
    for (int r = 0; r < rows; r++) begin
      for (int k = 0; k < keff; k++) begin
        plan.push_back(item_t'{P_LOAD, 5'(r), 4'(k)});
        plan.push_back(item_t'{P_MAC, 5'(r), 4'(k)});
      end
      plan.push_back(item_t'{P_STORE, 5'(r), 4'(keff - 1)});
    end
    cfg_rows = 5'(rows); cfg_ktiles = 4'(kts); start = 1'b1; abort = abort_with_start;
    @(posedge clk); #1;
    quiet();
    cfg_rows = 5'($urandom); cfg_ktiles = 4'($urandom);
    exp_err = 1'b0; exp_code = 2'b00;
    fr = '0; fk = '0;
    for (int i = 0; i < plan.size(); i++) begin
      it = plan[i];
      ncyc = (i == stall_at) ? int'(TO) : int'($urandom_range(dmax, dmin)) + 1;
      for (int c = 0; c < ncyc; c++) begin
        chk($sformatf("job%0d_step%0d_cyc%0d", job_no, i, c), obs_vec(),
            exp_vec(it.ph, (it.ph == P_MAC) && (it.kt == 0) && (c == 0), 1'b1, 1'b0, it.row, it.kt));
        drive(it.ph, (i != stall_at) && (c == ncyc - 1));
        abort = (i == abort_at) && (c == ncyc - 1);
        @(posedge clk); #1;
        quiet();
      end
      if (i == abort_at || i == stall_at) begin
        if (i == stall_at) begin
          exp_err = 1'b1; exp_code = it.ph;
        end
        chk($sformatf("job%0d_stop_idle", job_no), obs_vec(),
            exp_vec(P_IDLE, 1'b0, 1'b0, 1'b0, it.row, it.kt));
        @(posedge clk); #1;
        chk($sformatf("job%0d_stop_no_done", job_no), obs_vec(),
            exp_vec(P_IDLE, 1'b0, 1'b0, 1'b0, it.row, it.kt));
        return;
      end
      fr = it.row; fk = it.kt;
    end
    chk($sformatf("job%0d_done", job_no), obs_vec(), exp_vec(P_IDLE, 1'b0, 1'b1, 1'b1, fr, fk));
    @(posedge clk); #1;
    chk($sformatf("job%0d_idle", job_no), obs_vec(), exp_vec(P_IDLE, 1'b0, 1'b0, 1'b0, fr, fk));
  endtask

  initial begin
    rst_n = 1'b0; cfg_rows = '0; cfg_ktiles = '0;
    quiet();
    exp_err = 1'b0; exp_code = 2'b00;
    #1;
    chk("reset_outputs", obs_vec(), 18'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", obs_vec(), 18'h0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_in_idle", obs_vec(), 18'h0);

    run_job(2, 1, 1, 1, -1, -1, 1'b0);
    run_job(1, 3, 0, 2, -1, -1, 1'b0);
    run_job(0, 2, 0, 0, -1, -1, 1'b0);
    run_job(3, 2, 0, 3, 6, -1, 1'b0);
    run_job(2, 2, 0, 3, -1, -1, 1'b0);
    run_job(1, 0, 0, 1, -1, -1, 1'b1);
`ifdef MM_CTRL_TIMEOUT_EN
    run_job(1, 1, 0, 1, -1, 2, 1'b0);
    run_job(2, 1, 0, 1, -1, -1, 1'b0);
`endif

    // Asynchronous reset in the middle of a MAC phase.
    exp_err = 1'b0; exp_code = 2'b00;
    cfg_rows = 5'd2; cfg_ktiles = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("midjob_load", obs_vec(), exp_vec(P_LOAD, 1'b0, 1'b1, 1'b0, 5'd0, 4'd0));
    a_done = 1'b1;
    @(posedge clk); #1;
    a_done = 1'b0;
    chk("midjob_mac", obs_vec(), exp_vec(P_MAC, 1'b1, 1'b1, 1'b0, 5'd0, 4'd0));
    rst_n = 1'b0;
    #1;
    chk("async_reset_midjob", obs_vec(), 18'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int j = 0; j < 8; j++) begin
      run_job(int'($urandom_range(4, 1)), int'($urandom_range(4, 0)), 0, 3, -1, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mm_accel_ctrl_tiled.md
Name: mm_accel_ctrl_tiled

Overview:
- Parametrised control FSM for the row-oriented matrix-multiply accelerator.
- Sequences A-row buffering, MAC accumulation over a runtime number of K tiles, and C-row store.
- Counts rows internally against a runtime row count, so no external "full" flag is needed.
- Sits between the host start/config interface and the A/B fetch units, register file, MAC array and C store unit. Adds abort and an optional phase watchdog.

Parameters:
- MAX_ROWS, 16, largest supported row count; ROW_W = $clog2(MAX_ROWS+1).
- MAX_KTILES, 8, largest supported K-tile count per row; KT_W = $clog2(MAX_KTILES+1).
- TIMEOUT_CYCLES, 1024, watchdog limit per phase. Used only with MM_CTRL_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  start request; accepted only in IDLE.
- cfg_rows  in  ROW_W  rows to process; sampled on accepted start.
- cfg_ktiles  in  KT_W  K tiles per row; sampled on accepted start.
- abort  in  1  cancel the current job.
- a_done  in  1  register file and fetch-A both complete for the current tile.
- mac_done  in  1  MAC array and fetch-B both complete for the current tile.
- c_done  in  1  C-row store complete.
- load_a_en  out  1  drives register_enable and fetch_A.
- mac_en  out  1  drives MAC enable and fetch_B.
- mac_clear  out  1  accumulator clear, pulsed once per row.
- store_c_en  out  1  C store request.
- row_idx  out  ROW_W  current row.
- ktile_idx  out  KT_W  current K tile.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle job-complete pulse.
- err  out  1  sticky watchdog error.
- err_code  out  2  phase that timed out: 01 LOAD_A, 10 MAC, 11 STORE_C.

Behaviour:
- States: IDLE, LOAD_A, MAC, STORE_C, DONE. Binary or one-hot encoding is allowed; an illegal state returns to IDLE.
- All outputs are registered, and every output is 0 during reset.
- State-exact outputs, each high exactly during its state:
  - load_a_en in LOAD_A.
  - mac_en in MAC.
  - store_c_en in STORE_C.
  - done in DONE.
  - busy whenever state != IDLE.
- Outputs are decoded from next_state and registered, so they are valid in the first cycle of the new state with no extra lag.
- IDLE:
  - start=1 latches cfg_rows and cfg_ktiles, clears row_idx, ktile_idx and err, then goes to LOAD_A.
  - If latched rows=0, go to DONE directly.
  - Latched ktiles=0 is treated as 1.
- LOAD_A: stays while a_done=0; on a_done=1 goes to MAC.
- MAC:
  - mac_clear=1 only in the first MAC cycle of a row (ktile_idx==0). It is 0 in the first MAC cycle of later tiles and 0 in every other cycle.
  - On mac_done: if ktile_idx==ktiles-1, go to STORE_C; otherwise ktile_idx+1 and go to LOAD_A.
- STORE_C: on c_done, if row_idx==rows-1 go to DONE; otherwise row_idx+1, ktile_idx=0, go to LOAD_A.
- DONE: lasts exactly one cycle, then IDLE. row_idx and ktile_idx hold their final values until the next start.
- Latency:
  - start sampled at edge k puts the block in LOAD_A with load_a_en=1 after edge k.
  - Each phase completion moves state on the edge that samples the *_done input.
- Minimum cycles per row: ktiles*2 + 1.
- abort:
  - In any non-IDLE state, the next state is IDLE with all enables 0.
  - No done pulse; err unchanged.
  - abort wins over a simultaneous *_done.
  - abort in IDLE is ignored.
- start while busy is ignored and is not queued. start and abort together in IDLE: start is accepted.
- *_done inputs are ignored outside their own phase.
- Asynchronous reset mid-job returns the block to IDLE with all outputs 0 immediately.

Optional Feature:
- MM_CTRL_TIMEOUT_EN defined:
  - A cycle counter clears on every state entry and counts in LOAD_A, MAC and STORE_C.
  - If it reaches TIMEOUT_CYCLES before the phase's *_done, the next state is IDLE, err=1 (sticky), err_code = phase code, and there is no done pulse.
  - err and err_code clear only on reset or the next accepted start.
  - abort and *_done have priority over a timeout in the same cycle.
- MM_CTRL_TIMEOUT_EN undefined: no counter is built; err and err_code are tied 0; phases wait indefinitely.

Test Plan:
- cfg_rows=2, cfg_ktiles=1, each *_done asserted 1 cycle after its enable rises -> sequence LOAD_A, MAC, STORE_C twice; mac_clear pulses twice; single done pulse; row_idx ends at 1.
- cfg_rows=1, cfg_ktiles=3 -> LOAD_A/MAC alternate 3 times; mac_clear only in the first MAC cycle; ktile_idx steps 0,1,2; one STORE_C; then done.
- cfg_rows=0 -> busy=1 for exactly 1 cycle (DONE) with done=1; no enable ever asserts.
- abort asserted in the same cycle as mac_done during row 1 of 3 -> IDLE next cycle; mac_en and store_c_en never rise; done stays 0; a new start runs cleanly from row 0.
- start pulsed while in MAC, and a_done held high during MAC -> no effect on the sequence or counters.
- (MM_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16) c_done withheld -> IDLE after 16 STORE_C cycles; err=1, err_code=11; next start clears err.
